watch_time_keeper: RTL and testbench
====================================

# watch_time_keeper

Running-time counter of the watch controller: it reads the BCD digits produced by the time-setting front end and advances them in real time. On a `load` strobe it validates and captures hour/minute digits, then counts seconds, minutes and hours from a clock-cycle prescaler. It drives the display path and the alarm comparator. The time-setting block writes the digits; this block reads them.

## Interface
- `TICKS_PER_SEC`, default 1000: clock cycles per second; must be ≥2.
- `MODE24`, default 1: 1 = 00–23 hour range; 0 = 01–12 hour range with AM/PM flag.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `run`  in  1  count enable; 0 freezes the prescaler and all digits.
- `load`  in  1  single-cycle strobe; capture the `ld_*` digits.
- `ld_h1`, `ld_h0`, `ld_m1`, `ld_m0`  in  4 each  BCD digits to load.
- `h1`, `h0`, `m1`, `m0`, `s1`, `s0`  out  4 each  current time, BCD.
- `pm`  out  1  PM flag; 0 when `MODE24`=1.
- `sec_tick`  out  1  one-cycle pulse on every second advance.
- `min_tick`  out  1  one-cycle pulse when seconds wrap 59→00.
- `day_tick`  out  1  one-cycle pulse at midnight rollover.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset, `MODE24`=1: time is 00:00:00 and `pm`=0. Reset, `MODE24`=0: time is 12:00:00 and `pm`=0. At reset the prescaler is 0 and all tick and error outputs are 0.
- Prescaler `pcnt`:
  - When `run`=1, it counts 0..`TICKS_PER_SEC`-1.
  - At terminal count it returns to 0 and the time advances one second.
  - When `run`=0, `pcnt` holds its value and no ticks are generated.
- Second advance uses chained BCD digits:
  - `s0` counts 0–9. Its carry advances `s1` (0–5).
  - The `s1` carry advances `m0` (0–9), then `m1` (0–5), then the hour pair.
  - Digits never hold a non-BCD value.
- Hours, `MODE24`=1: 23:59:59 → 00:00:00, with `day_tick` asserted. The hour pair always passes 09→10 and 19→20.
- Hours, `MODE24`=0:
  - 12:59:59 → 01:00:00.
  - 11:59:59 → 12:00:00 with `pm` toggling.
  - `day_tick` asserts on the 11:59:59 PM → 12:00:00 AM transition.
- Load validation. A load is valid only if all of these hold:
  - every digit ≤9;
  - `ld_m1` ≤5;
  - the hour is 00–23 when `MODE24`=1, or 01–12 when `MODE24`=0.
- Valid load:
  - `h1`/`h0`/`m1`/`m0` take the loaded digits.
  - `s1`/`s0` go to 0 and `pcnt` goes to 0.
  - `pm` is unchanged.
- Invalid load: all state is unchanged and `load_err` pulses.
- Load and terminal count in the same cycle: load wins. The second advance is discarded and no tick pulses.
- Load while `run`=0 is accepted, and the time stays frozen after it.
- `reset` asserted mid-count clears immediately (asynchronously), regardless of `run` or `load`.

## Timing
- Every output is registered. There is no combinational path from input to output.
- Advance latency: on the edge where `run`=1 and `pcnt`=`TICKS_PER_SEC`-1, the new digits appear. On that same edge `sec_tick` rises, plus `min_tick` and `day_tick` where applicable. Each pulse lasts exactly one cycle.
- Load latency: `load` sampled high at edge N → new digits (or `load_err`) visible after edge N. The first following second completes `TICKS_PER_SEC` cycles after edge N, provided `run`=1 throughout.
- Back-to-back `load` strobes are each processed; the last valid one determines the time.

## Structure
- Shared package `watch_pkg` holds:
  - typedef `bcd_t` (4-bit);
  - constants for digit maxima (9, 5) and hour limits (23, 12, 1);
  - the 12:00:00 reset constant.
- Sub-module `bcd_digit_counter`: one BCD digit with parameter `MAX`, inputs `en`/`clr`/`ld`/`ld_val`, and outputs `q` and terminal-count carry `tc`. It is instantiated for `s0`, `s1`, `m0` and `m1`.
- The hour pair and `pm` need non-uniform wrap, so they are a dedicated always-block in the top level.
- Validation is a combinational function in the top level.

## Test plan
All scenarios use `TICKS_PER_SEC`=4.
- Reset with `MODE24`=1 → 00:00:00, `pm`=0. Then `run`=1 for 40 cycles → 00:00:10; `sec_tick` pulses 10 times, every 4th cycle.
- Load 23:59 with `run`=1, then wait 240 cycles → 00:00:00. `min_tick` and `day_tick` assert together on that edge.
- `MODE24`=0: load 11:59 AM, run 60 s → 12:00:00 with `pm`=1. Then load 12:59 and run 60 s → 01:00:00 with `pm` unchanged.
- Invalid loads each give `load_err`=1 for one cycle with time unchanged:
  - 24:00 when `MODE24`=1;
  - 00:30 when `MODE24`=0;
  - `ld_m1`=6;
  - `ld_h0`=0xA.
- `load` asserted exactly on a terminal-count cycle → loaded digits with seconds 00, no `sec_tick`. Next `sec_tick` arrives 4 cycles later.
- Assert `reset` for one cycle mid-second at 05:43:21 → 00:00:00 immediately with `pcnt`=0. Also check that `run`=0 holds the time for 100 cycles.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-keeping datapath.
package watch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX9 = 4'd9;
    localparam bcd_t DIGIT_MAX5 = 4'd5;

    localparam int HOUR24_MAX = 23;
    localparam int HOUR12_MAX = 12;
    localparam int HOUR12_MIN = 1;

    typedef struct packed {
        bcd_t h1;
        bcd_t h0;
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
    } bcd_time_t;

    localparam bcd_time_t RESET_TIME_12 = bcd_time_t'(24'h12_0000);

    function automatic int bcd_pair_val(input bcd_t hi, input bcd_t lo);
        return 10 * int'(hi) + int'(lo);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..MAX with clear, parallel load and terminal-count carry.
module bcd_digit_counter
    import watch_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX9
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic ld,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic tc
);

    bcd_t q_q, q_d;

    // Wrapping on >= MAX keeps the digit in range even from an unexpected value.
    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (ld)
            q_d = ld_val;
        else if (en)
            q_d = (q_q >= MAX) ? '0 : q_q + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q  = q_q;
    assign tc = (q_q == MAX);

endmodule

// File: rtl/watch_time_keeper.sv
// Real-time BCD clock: prescaled second advance, chained digit counters,
// 12/24-hour wrap with AM/PM, and validated loading of hour/minute digits.
module watch_time_keeper
    import watch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter bit MODE24        = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       load,
    input  logic [3:0] ld_h1,
    input  logic [3:0] ld_h0,
    input  logic [3:0] ld_m1,
    input  logic [3:0] ld_m0,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       pm,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       day_tick,
    output logic       load_err
);

    localparam int            PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICKS_PER_SEC - 1);

    function automatic logic load_ok(input bcd_t dh1, input bcd_t dh0,
                                     input bcd_t dm1, input bcd_t dm0);
        int hr;
        hr = bcd_pair_val(dh1, dh0);
        if (dh1 > DIGIT_MAX9 || dh0 > DIGIT_MAX9 || dm1 > DIGIT_MAX5 || dm0 > DIGIT_MAX9)
            return 1'b0;
        if (MODE24)
            return hr <= HOUR24_MAX;
        return (hr >= HOUR12_MIN) && (hr <= HOUR12_MAX);
    endfunction

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          ld_valid, ld_bad, at_tc, adv;
    logic          s0_tc, s1_tc, m0_tc, m1_tc, min_wrap, hour_en;
    bcd_t          h1_q, h1_d, h0_q, h0_d;
    logic          pm_q, pm_d, day_d;
    logic          sec_q, min_q, day_q, err_q;

    assign ld_valid = load && load_ok(ld_h1, ld_h0, ld_m1, ld_m0);
    assign ld_bad   = load && !ld_valid;
    assign at_tc    = run && (pcnt_q == PCNT_LAST);
    // Any load, accepted or not, swallows a coincident second advance.
    assign adv      = at_tc && !load;
    assign min_wrap = adv && s0_tc && s1_tc;
    assign hour_en  = min_wrap && m0_tc && m1_tc;

    always_comb begin
        pcnt_d = pcnt_q;
        if (ld_valid)
            pcnt_d = '0;
        else if (!load && run)
            pcnt_d = at_tc ? '0 : pcnt_q + 1'b1;
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX9)) u_s0 (
        .clk(clk), .reset(reset), .en(adv), .clr(ld_valid), .ld(1'b0),
        .ld_val('0), .q(s0), .tc(s0_tc)
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX5)) u_s1 (
        .clk(clk), .reset(reset), .en(adv && s0_tc), .clr(ld_valid), .ld(1'b0),
        .ld_val('0), .q(s1), .tc(s1_tc)
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX9)) u_m0 (
        .clk(clk), .reset(reset), .en(min_wrap), .clr(1'b0), .ld(ld_valid),
        .ld_val(ld_m0), .q(m0), .tc(m0_tc)
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX5)) u_m1 (
        .clk(clk), .reset(reset), .en(min_wrap && m0_tc), .clr(1'b0), .ld(ld_valid),
        .ld_val(ld_m1), .q(m1), .tc(m1_tc)
    );

    // Hour pair wraps non-uniformly, so it is handled here rather than by digit counters.
    always_comb begin
        h1_d  = h1_q;
        h0_d  = h0_q;
        pm_d  = pm_q;
        day_d = 1'b0;
        if (ld_valid) begin
            h1_d = ld_h1;
            h0_d = ld_h0;
        end else if (hour_en) begin
            if (MODE24 && bcd_pair_val(h1_q, h0_q) >= HOUR24_MAX) begin
                h1_d  = 4'd0;
                h0_d  = 4'd0;
                day_d = 1'b1;
            end else if (!MODE24 && bcd_pair_val(h1_q, h0_q) == HOUR12_MAX) begin
                h1_d = 4'd0;
                h0_d = 4'd1;
            end else if (!MODE24 && bcd_pair_val(h1_q, h0_q) == HOUR12_MAX - 1) begin
                h1_d  = 4'd1;
                h0_d  = 4'd2;
                pm_d  = !pm_q;
                day_d = pm_q;
            end else if (h0_q >= DIGIT_MAX9) begin
                h1_d = h1_q + 4'd1;
                h0_d = 4'd0;
            end else begin
                h0_d = h0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
            h1_q   <= MODE24 ? 4'd0 : RESET_TIME_12.h1;
            h0_q   <= MODE24 ? 4'd0 : RESET_TIME_12.h0;
            pm_q   <= 1'b0;
            sec_q  <= 1'b0;
            min_q  <= 1'b0;
            day_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            h1_q   <= h1_d;
            h0_q   <= h0_d;
            pm_q   <= pm_d;
            sec_q  <= adv;
            min_q  <= min_wrap;
            day_q  <= day_d;
            err_q  <= ld_bad;
        end
    end

    assign h1       = h1_q;
    assign h0       = h0_q;
    assign pm       = pm_q;
    assign sec_tick = sec_q;
    assign min_tick = min_q;
    assign day_tick = day_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_watch_time_keeper.sv
// Scoreboard bench: a 24-hour and a 12-hour instance share stimulus and are
// checked against a seconds-of-day reference model.
module tb_watch_time_keeper;

    localparam int TPS = 4;

    typedef struct packed {
        logic [23:0] t;
        logic        pm;
        logic        sec;
        logic        mn;
        logic        day;
        logic        err;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld_h1 = '0, ld_h0 = '0, ld_m1 = '0, ld_m0 = '0;

    logic [3:0] a_h1, a_h0, a_m1, a_m0, a_s1, a_s0;
    logic       a_pm, a_sec, a_min, a_day, a_err;
    logic [3:0] b_h1, b_h0, b_m1, b_m0, b_s1, b_s0;
    logic       b_pm, b_sec, b_min, b_day, b_err;

    obs_t act_a, act_b;
    assign act_a = {a_h1, a_h0, a_m1, a_m0, a_s1, a_s0, a_pm, a_sec, a_min, a_day, a_err};
    assign act_b = {b_h1, b_h0, b_m1, b_m0, b_s1, b_s0, b_pm, b_sec, b_min, b_day, b_err};

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    int t24 = 0, pc24 = 0, t12 = 0, pc12 = 0;

    watch_time_keeper #(.TICKS_PER_SEC(TPS), .MODE24(1'b1)) dut24 (
        .clk(clk), .reset(reset), .run(run), .load(load),
        .ld_h1(ld_h1), .ld_h0(ld_h0), .ld_m1(ld_m1), .ld_m0(ld_m0),
        .h1(a_h1), .h0(a_h0), .m1(a_m1), .m0(a_m0), .s1(a_s1), .s0(a_s0),
        .pm(a_pm), .sec_tick(a_sec), .min_tick(a_min), .day_tick(a_day), .load_err(a_err)
    );

    watch_time_keeper #(.TICKS_PER_SEC(TPS), .MODE24(1'b0)) dut12 (
        .clk(clk), .reset(reset), .run(run), .load(load),
        .ld_h1(ld_h1), .ld_h0(ld_h0), .ld_m1(ld_m1), .ld_m0(ld_m0),
        .h1(b_h1), .h0(b_h0), .m1(b_m1), .m0(b_m0), .s1(b_s1), .s0(b_s0),
        .pm(b_pm), .sec_tick(b_sec), .min_tick(b_min), .day_tick(b_day), .load_err(b_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t render(input bit m24, input int t, input bit sec,
                                    input bit mn, input bit day, input bit err);
        obs_t o;
        int h24, h, m, s;
        h24 = t / 3600;
        h   = m24 ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
        m   = (t / 60) % 60;
        s   = t % 60;
        o.t   = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        o.pm  = m24 ? 1'b0 : (h24 >= 12);
        o.sec = sec;
        o.mn  = mn;
        o.day = day;
        o.err = err;
        return o;
    endfunction

    function automatic bit load_valid(input bit m24, input int a, input int b,
                                      input int c, input int d);
        int h;
        if (a > 9 || b > 9 || c > 5 || d > 9) return 1'b0;
        h = a * 10 + b;
        return m24 ? (h <= 23) : (h >= 1 && h <= 12);
    endfunction

    // Time is seconds since midnight; 12-hour loads keep the current AM/PM half.
    task automatic model_step(input bit m24, inout int t, inout int pc, output obs_t o);
        bit sec, mn, day, err;
        int a, b, c, d, h;
        sec = 0; mn = 0; day = 0; err = 0;
        a = int'(ld_h1); b = int'(ld_h0); c = int'(ld_m1); d = int'(ld_m0);
        if (load) begin
            if (load_valid(m24, a, b, c, d)) begin
                h = a * 10 + b;
                if (!m24) h = (h % 12) + ((t / 3600 >= 12) ? 12 : 0);
                t  = h * 3600 + (c * 10 + d) * 60;
                pc = 0;
            end else begin
                err = 1;
            end
        end else if (run) begin
            if (pc == TPS - 1) begin
                pc  = 0;
                t   = (t + 1) % 86400;
                sec = 1;
                mn  = (t % 60 == 0);
                day = (t == 0);
            end else begin
                pc++;
            end
        end
        o = render(m24, t, sec, mn, day, err);
    endtask

    task automatic chk(input string nm, input obs_t act, input obs_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got time=%h pm=%b sec=%b min=%b day=%b err=%b, expected time=%h pm=%b sec=%b min=%b day=%b err=%b",
                      nm, act.t, act.pm, act.sec, act.mn, act.day, act.err,
                      exp.t, exp.pm, exp.sec, exp.mn, exp.day, exp.err);
    endtask

    task automatic cyc(input bit r, input bit l, input int a, input int b, input int c, input int d);
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        run   = r;
        load  = l;
        ld_h1 = 4'(a); ld_h0 = 4'(b); ld_m1 = 4'(c); ld_m0 = 4'(d);
        model_step(1'b1, t24, pc24, e.a);
        model_step(1'b0, t12, pc12, e.b);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        #1;
        chk("async_reset_24", act_a, render(1'b1, 0, 0, 0, 0, 0));
        chk("async_reset_12", act_b, render(1'b0, 0, 0, 0, 0, 0));
        t24 = 0; pc24 = 0; t12 = 0; pc12 = 0;
        e.a = render(1'b1, 0, 0, 0, 0, 0);
        e.b = render(1'b0, 0, 0, 0, 0, 0);
        sb.push_back(e);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dut24", act_a, e.a);
                chk("dut12", act_b, e.b);
            end
        end
    end

    initial begin : stimulus
        int guard, hr, mi;
        do_reset();
        run_n(40);
        cyc(1, 1, 2, 3, 5, 9);
        run_n(240);
        cyc(1, 1, 1, 1, 5, 9);
        run_n(240);
        cyc(1, 1, 1, 2, 5, 9);
        run_n(240);
        cyc(1, 1, 1, 1, 5, 9);
        run_n(240);
        // Rejected loads, back to back, with the clock frozen.
        cyc(0, 1, 2, 4, 0, 0);
        cyc(0, 1, 0, 0, 3, 0);
        cyc(0, 1, 0, 5, 6, 0);
        cyc(0, 1, 0, 10, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // Load coinciding with terminal count.
        cyc(1, 1, 0, 5, 4, 3);
        run_n(9);
        guard = 0;
        while (pc24 != TPS - 1 && guard < 10) begin
            cyc(1, 0, 0, 0, 0, 0);
            guard++;
        end
        cyc(1, 1, 0, 8, 1, 5);
        run_n(8);
        // Asynchronous reset mid-second at 05:43:21.
        cyc(1, 1, 0, 5, 4, 3);
        run_n(21 * TPS + 2);
        do_reset();
        run_n(20);
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 0, 0, 0, 0);
        run_n(10);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else if ($urandom_range(19) == 0) begin
                if ($urandom_range(3) != 0) begin
                    hr = $urandom_range(12, 0);
                    mi = $urandom_range(59, 0);
                    cyc($urandom_range(9) != 0, 1'b1, hr / 10, hr % 10, mi / 10, mi % 10);
                end else begin
                    cyc($urandom_range(9) != 0, 1'b1, $urandom_range(15), $urandom_range(15),
                        $urandom_range(15), $urandom_range(15));
                end
            end else begin
                cyc($urandom_range(9) != 0, 1'b0, $urandom_range(15), $urandom_range(15),
                    $urandom_range(15), $urandom_range(15));
            end
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
